// File: rtl/pc_jump_pkg.sv
// Shared definitions for the program-counter unit.
// Contents: jump-mode encoding and the sequential instruction increment.
package pc_jump_pkg;

  typedef enum logic [1:0] {
    JP_RELATIVE = 2'd0,
    JP_TO_F     = 2'd1,
    JP_RETURN   = 2'd2,
    JP_RSVD     = 2'd3
  } jump_sel_e;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit <-> pc_unit bus.
// master: the control unit drives step/stall/jump/jump_sel/link/alu_f/rel_addr
//         and observes the pc state and pulses.
// slave : pc_unit, the mirror image.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            step;
  logic            stall;
  logic            jump;
  logic [1:0]      jump_sel;
  logic            link;
  logic [XLEN-1:0] alu_f;
  logic [XLEN-1:0] rel_addr;
  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] ret_addr;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;
  logic            ras_underflow;

  modport master (
    output step, stall, jump, jump_sel, link, alu_f, rel_addr,
    input  inst_addr, cur_addr, ret_addr, ras_empty, ras_full,
           misaligned, ras_underflow
  );

  modport slave (
    input  step, stall, jump, jump_sel, link, alu_f, rel_addr,
    output inst_addr, cur_addr, ret_addr, ras_empty, ras_full,
           misaligned, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack.
// Ports: clk/rst (sync, active high), push/pop with push_data,
//        top (combinational view of newest entry), empty/full (registered).
// A push into a full stack overwrites the oldest entry; push+pop together
// replaces the top in place. The caller must not pop an empty stack; such a
// pop is ignored here anyway.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   wptr;      // next free slot; newest entry sits at wptr-1
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            pop_ok;

  assign top_ptr = wptr - PW'(1);
  assign top     = mem[top_ptr];
  assign pop_ok  = pop && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop_ok) begin
      if (count != CW'(RAS_DEPTH)) count_nxt = count + CW'(1);
    end else if (pop_ok && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push && !pop_ok)      wptr <= wptr + PW'(1);
      else if (pop_ok && !push) wptr <= top_ptr;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(RAS_DEPTH));
    end
  end

  // Entry storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (pop_ok) mem[top_ptr] <= push_data;
      else        mem[wptr]    <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address, execute address, jump resolution
// and call/return tracking through a return-address stack.
// Ports: clk, rst (sync, active high), bus (pc_unit_if.slave) carrying
//        step/stall/jump/jump_sel/link/alu_f/rel_addr in and
//        inst_addr/cur_addr/ret_addr/ras_empty/ras_full/misaligned/
//        ras_underflow out.
// Priority: rst > stall > jump > step.
module pc_unit
  import pc_jump_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);
  logic [XLEN-1:0] pc_q, cur_q, ret_q;
  logic            mis_q, und_q;
  logic [XLEN-1:0] target, link_addr, ras_top;
  logic            ras_empty, ras_full;
  logic            taken, bad_align, accept, do_step;
  logic            ras_push, ras_pop, mis_nxt, und_nxt;

  assign link_addr = cur_q + XLEN'(INST_BYTES);

  always_comb begin
    target = '0;
    case (jump_sel_e'(bus.jump_sel))
      JP_RELATIVE: target = cur_q + bus.rel_addr;
      JP_TO_F:     target = {bus.alu_f[XLEN-1:1], 1'b0};
      JP_RETURN:   target = ras_empty ? {bus.alu_f[XLEN-1:1], 1'b0} : ras_top;
      default:     target = '0;
    endcase
  end

  // Reserved jump mode is treated as "no jump" so step still applies.
  assign taken     = !bus.stall && bus.jump && (bus.jump_sel != JP_RSVD);
  assign bad_align = (target[1:0] != 2'b00);
  assign accept    = taken && !bad_align;
  assign do_step   = !bus.stall && !taken && bus.step;
  assign ras_push  = accept && bus.link;
  assign ras_pop   = accept && (bus.jump_sel == JP_RETURN) && !ras_empty;
  assign mis_nxt   = taken && bad_align;
  assign und_nxt   = taken && (bus.jump_sel == JP_RETURN) && ras_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      cur_q <= RESET_VECTOR;
      ret_q <= '0;
      mis_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      mis_q <= mis_nxt;
      und_q <= und_nxt;
      if (accept) begin
        pc_q  <= target;
        cur_q <= target;
        if (bus.link) ret_q <= link_addr;
      end else if (do_step) begin
        cur_q <= pc_q;
        pc_q  <= pc_q + XLEN'(INST_BYTES);
      end
    end
  end

  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (link_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.inst_addr     = pc_q;
  assign bus.cur_addr      = cur_q;
  assign bus.ret_addr      = ret_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.misaligned    = mis_q;
  assign bus.ras_underflow = und_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc, cur, ret;
    logic        empty, full, mis, und;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  // Reference model: stack as a plain queue, newest at the back.
  logic [31:0] m_pc, m_cur, m_ret;
  logic [31:0] m_ras[$];
  logic        m_mis, m_und;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(input bit r, st, stl, j, input logic [1:0] sel,
                       input bit lk, input logic [31:0] af, rl);
    logic [31:0] tgt;
    bit from_ras;
    if (r) begin
      m_pc = 0; m_cur = 0; m_ret = 0; m_ras.delete(); m_mis = 0; m_und = 0;
    end else if (stl) begin
      m_mis = 0; m_und = 0;
    end else begin
      m_mis = 0; m_und = 0;
      if (j && sel != 2'd3) begin
        from_ras = 0;
        case (sel)
          2'd0: tgt = m_cur + rl;
          2'd1: tgt = af & 32'hFFFF_FFFE;
          default: begin
            if (m_ras.size() == 0) begin
              tgt = af & 32'hFFFF_FFFE; m_und = 1;
            end else begin
              tgt = m_ras[m_ras.size()-1]; from_ras = 1;
            end
          end
        endcase
        if (tgt[1:0] != 2'b00) m_mis = 1;
        else begin
          if (from_ras && lk) m_ras[m_ras.size()-1] = m_cur + 4;
          else begin
            if (from_ras) void'(m_ras.pop_back());
            if (lk) begin
              m_ras.push_back(m_cur + 4);
              if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
          end
          if (lk) m_ret = m_cur + 4;
          m_pc = tgt; m_cur = tgt;
        end
      end else if (st) begin
        m_cur = m_pc; m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic drive(input bit r, st, stl, j, input logic [1:0] sel,
                       input bit lk, input logic [31:0] af, rl);
    exp_t e;
    @(negedge clk);
    rst = r; bus.step = st; bus.stall = stl; bus.jump = j; bus.jump_sel = sel;
    bus.link = lk; bus.alu_f = af; bus.rel_addr = rl;
    model(r, st, stl, j, sel, lk, af, rl);
    e.pc = m_pc; e.cur = m_cur; e.ret = m_ret;
    e.empty = (m_ras.size() == 0); e.full = (m_ras.size() == DEPTH);
    e.mis = m_mis; e.und = m_und;
    exp_q.push_back(e);
  endtask

  // Wait until just after the edge that consumed the last drive.
  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic do_step();             drive(0,1,0,0,2'd0,0,0,0); endtask
  task automatic do_reset();            drive(1,0,0,0,2'd0,0,0,0); endtask
  task automatic call_f(input logic [31:0] a);  drive(0,0,0,1,2'd1,1,a,0); endtask
  task automatic ret_j(input logic [31:0] a);   drive(0,0,0,1,2'd2,0,a,0); endtask

  // Monitor: every edge presents a new state; compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_addr", bus.inst_addr, e.pc);
        chk("cur_addr", bus.cur_addr, e.cur);
        chk("ret_addr", bus.ret_addr, e.ret);
        chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
        chk("ras_full", 32'(bus.ras_full), 32'(e.full));
        chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
        chk("ras_underflow", 32'(bus.ras_underflow), 32'(e.und));
      end
    end
  end

  initial begin
    bus.step = 0; bus.stall = 0; bus.jump = 0; bus.jump_sel = 0;
    bus.link = 0; bus.alu_f = 0; bus.rel_addr = 0;

    // Reset then three steps.
    do_reset(); settle();
    chk("reset_pc", bus.inst_addr, 32'h0);
    chk("reset_empty", 32'(bus.ras_empty), 32'd1);
    do_step(); do_step(); do_step(); settle();
    chk("step3_pc", bus.inst_addr, 32'hC);
    chk("step3_cur", bus.cur_addr, 32'h8);

    // Relative jump backwards with link; step ignored.
    do_step(); do_step(); settle();
    chk("pre_rel_cur", bus.cur_addr, 32'h10);
    drive(0,1,0,1,2'd0,1,0,32'hFFFF_FFF8); settle();
    chk("rel_pc", bus.inst_addr, 32'h8);
    chk("rel_ret", bus.ret_addr, 32'h14);

    // Absolute target with bit0 masked, then a misaligned one.
    drive(0,0,0,1,2'd1,0,32'h201,0); settle();
    chk("tof_pc", bus.inst_addr, 32'h200);
    drive(0,1,0,1,2'd1,0,32'h202,0); settle();
    chk("mis_pulse", 32'(bus.misaligned), 32'd1);
    chk("mis_pc", bus.inst_addr, 32'h200);
    // RAS top still 0x14 from the earlier call.
    ret_j(0); settle();
    chk("ras_top_014", bus.inst_addr, 32'h14);

    // Five calls overflow a 4-deep stack; five returns.
    do_reset();
    call_f(32'h10); call_f(32'h20); call_f(32'h30); call_f(32'h40); call_f(32'h100);
    settle();
    chk("ras_full", 32'(bus.ras_full), 32'd1);
    ret_j(0); settle(); chk("ret1", bus.inst_addr, 32'h44);
    ret_j(0); settle(); chk("ret2", bus.inst_addr, 32'h34);
    ret_j(0); settle(); chk("ret3", bus.inst_addr, 32'h24);
    ret_j(0); settle(); chk("ret4", bus.inst_addr, 32'h14);
    ret_j(32'h301); settle();
    chk("underflow_pc", bus.inst_addr, 32'h300);
    chk("underflow_pulse", 32'(bus.ras_underflow), 32'd1);

    // Stall beats jump and step; reset beats jump.
    drive(0,1,1,1,2'd1,1,32'h500,0); settle();
    chk("stall_pc", bus.inst_addr, 32'h300);
    drive(1,1,0,1,2'd1,1,32'h500,0); settle();
    chk("rst_jump_pc", bus.inst_addr, 32'h0);
    chk("rst_jump_empty", 32'(bus.ras_empty), 32'd1);

    // Coroutine swap: top 0x44, cur 0x80.
    call_f(32'h40); call_f(32'h80);
    drive(0,0,0,1,2'd2,1,0,0); settle();
    chk("swap_pc", bus.inst_addr, 32'h44);
    ret_j(0); settle();
    chk("swap_newtop", bus.inst_addr, 32'h84);
    ret_j(0); settle();
    chk("swap_count", bus.inst_addr, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit r, st, stl, j, lk;
      logic [1:0] sel;
      logic [31:0] af, rl;
      r   = ($urandom_range(0, 63) == 0);
      stl = ($urandom_range(0, 7) == 0);
      j   = ($urandom_range(0, 1) == 1);
      st  = ($urandom_range(0, 3) != 0);
      lk  = ($urandom_range(0, 2) == 0);
      sel = 2'($urandom_range(0, 3));
      af  = $urandom;
      if ($urandom_range(0, 3) != 0) af = af & 32'hFFFF_FFFC;
      rl  = 32'($signed($urandom_range(0, 63)) - 32) << 2;
      if ($urandom_range(0, 7) == 0) rl = rl | 32'h2;
      drive(r, st, stl, j, sel, lk, af, rl);
    end
    drive(0,0,0,0,2'd0,0,0,0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the RISC-V core.
- Generates the fetch address and tracks the address of the instruction in execute.
- Resolves relative, register-indirect and return jumps.
- Holds a circular return-address stack (RAS) for call/return.
- Sits between the control unit (step/jump/link/stall) and instruction memory; all state updates on the rising clock edge.

Parameters:
- XLEN, 32, address/data width in bits.
- RESET_VECTOR, 0, value of inst_addr after reset.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- step  in  1  advance to the next sequential instruction.
- stall  in  1  freeze all state (except reset).
- jump  in  1  take a jump this cycle.
- jump_sel  in  2  jump mode: JP_RELATIVE, JP_TO_F, JP_RETURN.
- link  in  1  with jump: write ret_addr and push it onto the RAS.
- alu_f  in  XLEN  absolute target from the ALU.
- rel_addr  in  XLEN  signed offset, added to cur_addr.
- inst_addr  out  XLEN  fetch address (pc register).
- cur_addr  out  XLEN  address of the instruction in execute.
- ret_addr  out  XLEN  last link address.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misaligned  out  1  one-cycle pulse: rejected jump target.
- ras_underflow  out  1  one-cycle pulse: return taken with an empty RAS.

Behaviour:
- Reset (rst=1 at a clock edge): inst_addr=RESET_VECTOR, cur_addr=RESET_VECTOR, ret_addr=0, RAS count=0, ras_empty=1, ras_full=0, pulses=0. Reset overrides every other input, including mid-jump.
- Priority: rst > stall > jump > step.
- Stall: all registers hold and pulses are 0.
- step (no jump): cur_addr<=inst_addr, inst_addr<=inst_addr+4. Takes one cycle; the new inst_addr is visible after the edge.
- Jump target by mode:
  - JP_RELATIVE: target=cur_addr+rel_addr (mod 2^XLEN, wraps silently).
  - JP_TO_F: target=alu_f with bit0 cleared.
  - JP_RETURN: target=RAS top.
  - jump_sel=2'b11: jump ignored; falls through to step behaviour.
- Accepted jump: inst_addr<=target, cur_addr<=target. step in the same cycle is ignored.
- Misaligned target (target[1:0]≠0 after masking): no register changes, no RAS push/pop; misaligned=1 for one cycle.
- link with an accepted jump: ret_addr<=cur_addr+4 and the same value is pushed onto the RAS. link without jump has no effect.
- RAS is circular with a write pointer and a saturating count:
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop decrements the pointer and count.
- JP_RETURN with the RAS empty: target=alu_f with bit0 cleared; ras_underflow=1 for one cycle; pointer unchanged.
- JP_RETURN with link (coroutine swap): pop and push in the same cycle. The top entry is replaced by cur_addr+4, the pointer and count are unchanged, and the target is the old top.
- ras_empty and ras_full are registered flags derived from the count after the edge.
- Widths: all address arithmetic is XLEN bits; carries are discarded.

Decomposition:
- Shared package pc_jump_pkg holds:
  - JP_RELATIVE=2'd0, JP_TO_F=2'd1, JP_RETURN=2'd2, JP_RSVD=2'd3.
  - Instruction increment constant INST_BYTES=4.
- Natural sub-module: ras_stack (params XLEN, RAS_DEPTH).
  - Inputs: clk, rst, push, pop, push_data.
  - Outputs: top, empty, full.
  - Implements the circular overwrite and simultaneous push/pop rules.
- pc_unit contains the target mux, alignment check and pc/cur/ret registers.

Test Plan:
- Reset then 3×step -> inst_addr 0x0 -> 0x4 -> 0x8 -> 0xC; cur_addr 0x8; ras_empty=1.
- cur_addr=0x10, JP_RELATIVE, rel_addr=0xFFFFFFF8, link=1, step=1 -> inst_addr=0x8, ret_addr=0x14, RAS top=0x14, step ignored.
- JP_TO_F with alu_f=0x201 -> inst_addr=0x200; then JP_TO_F with alu_f=0x202 -> misaligned pulse, inst_addr stays 0x200, RAS unchanged.
- RAS_DEPTH=4: five linked calls from 0x0,0x10,0x20,0x30,0x40 -> ras_full=1; five returns -> targets 0x44,0x34,0x24,0x14, then ras_underflow with target alu_f.
- stall=1 with jump=1 and step=1 -> no state change; rst=1 together with jump -> inst_addr=RESET_VECTOR, RAS empty.
- Return with link when top=0x44 and cur_addr=0x80 -> inst_addr=0x44, new top=0x84, count unchanged.
